// File: rtl/donut_rom_arbiter.sv
// donut_rom_arbiter
//   Shares one registered-output ROM between two read requesters.
//   Requester 0 (display) has fixed priority. Requester 1 (auxiliary) gets a
//   forced grant after STARVE_MAX consecutive denied cycles. Grants are
//   combinational. Read data comes back exactly two cycles after the grant,
//   in grant order, and one read per cycle can be sustained.
//
// Ports
//   clk_i, rst_i          clock and synchronous active-high reset
//   en_i                  arbitration enable (in-flight reads still drain)
//   rN_req_i / rN_addr_i  read request and address, held until granted
//   rN_gnt_o              combinational grant
//   rN_valid_o            one-cycle pulse while rN_data_o holds new data
//   rN_data_o             registered read data, held until the next own read
//   rom_cen_o/rom_addr_o  ROM read strobe and address (combinational)
//   rom_data_i            ROM data, valid the cycle after rom_cen_o
module donut_rom_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        r0_req_i,
    input  logic [14:0] r0_addr_i,
    output logic        r0_gnt_o,
    output logic        r0_valid_o,
    output logic [3:0]  r0_data_o,
    input  logic        r1_req_i,
    input  logic [14:0] r1_addr_i,
    output logic        r1_gnt_o,
    output logic        r1_valid_o,
    output logic [3:0]  r1_data_o,
    output logic        rom_cen_o,
    output logic [14:0] rom_addr_o,
    input  logic [3:0]  rom_data_i
);

    localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

    logic [7:0] starve_reg;
    logic [7:0] starve_next;

    // In-flight tags {valid, owner}: tag1 is the cycle the ROM is reading,
    // tag2 is the cycle the captured data is presented.
    logic [1:0] tag1_reg;
    logic [1:0] tag2_reg;

    logic       arb_ok;
    logic       force1;
    logic       gnt0;
    logic       gnt1;
    logic [3:0] data_reg [2];
    logic [1:0] valid_vec;

    assign arb_ok = en_i & ~rst_i;
    assign force1 = arb_ok & r1_req_i & (starve_reg == STARVE_LIMIT);
    assign gnt0   = arb_ok & r0_req_i & ~force1;
    // Requester 1 wins whenever requester 0 does not; this covers both the
    // idle-r0 case and the forced (starved) case.
    assign gnt1   = arb_ok & r1_req_i & ~gnt0;

    assign r0_gnt_o   = gnt0;
    assign r1_gnt_o   = gnt1;
    assign rom_cen_o  = gnt0 | gnt1;
    assign rom_addr_o = gnt0 ? r0_addr_i : (gnt1 ? r1_addr_i : 15'd0);

    // Starvation counter: frozen while arbitration is disabled, cleared when
    // requester 1 is served or idle, otherwise counts denied cycles.
    always_comb begin
        starve_next = starve_reg;
        if (en_i) begin
            if (gnt1 || !r1_req_i) begin
                starve_next = 8'd0;
            end else if (starve_reg != STARVE_LIMIT) begin
                starve_next = starve_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_reg <= 8'd0;
            tag1_reg   <= 2'b00;
            tag2_reg   <= 2'b00;
        end else begin
            starve_reg <= starve_next;
            tag1_reg   <= {gnt0 | gnt1, gnt1};
            tag2_reg   <= tag1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            // ROM output is valid while tag1 is live; capture it for the owner.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    data_reg[gi] <= 4'd0;
                end else if (tag1_reg[1] && (tag1_reg[0] == 1'(gi))) begin
                    data_reg[gi] <= rom_data_i;
                end
            end
            // Masked by reset so a read caught in flight never pulses.
            assign valid_vec[gi] = tag2_reg[1] & (tag2_reg[0] == 1'(gi)) & ~rst_i;
        end
    endgenerate

    assign r0_valid_o = valid_vec[0];
    assign r1_valid_o = valid_vec[1];
    assign r0_data_o  = data_reg[0];
    assign r1_data_o  = data_reg[1];

endmodule

// File: doc/donut_rom_arbiter.md
DONUT_ROM_ARBITER -- requirements
Module: donut_rom_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 8, meaning consecutive denied cycles of requester 1 before a forced grant (legal range 1..255).
REQ-002 The block SHALL have port clk_i  input  1  single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port en_i  input  1  arbitration enable; when low, no new grants are issued.
REQ-005 The block SHALL have port r0_req_i  input  1  display requester read request, held until granted.
REQ-006 The block SHALL have port r0_addr_i  input  15  display read address, stable while r0_req_i is high.
REQ-007 The block SHALL have port r0_gnt_o  output  1  combinational grant to requester 0.
REQ-008 The block SHALL have port r0_valid_o  output  1  one-cycle pulse: r0_data_o holds new read data.
REQ-009 The block SHALL have port r0_data_o  output  4  registered read data for requester 0.
REQ-010 The block SHALL have ports r1_req_i, r1_addr_i, r1_gnt_o, r1_valid_o and r1_data_o, with the same directions, widths and meanings as REQ-005..009, for the auxiliary requester.
REQ-011 The block SHALL have port rom_cen_o  output  1  ROM clock enable, combinational.
REQ-012 The block SHALL have port rom_addr_o  output  15  ROM read address, combinational.
REQ-013 The block SHALL have port rom_data_i  input  4  ROM registered read data, valid one cycle after a cycle with rom_cen_o high.

Function
REQ-014 The block SHALL assert at most one grant per cycle, and only when en_i=1 and rst_i=0.
REQ-015 Requester 0 SHALL win any cycle in which both requesters request, except when REQ-017 applies.
REQ-016 An 8-bit starvation counter SHALL behave as follows:
- increment, saturating at STARVE_MAX, in each cycle where r1_req_i=1 and r1_gnt_o=0 and en_i=1;
- clear to 0 when r1 is granted or r1_req_i=0;
- hold when en_i=0.
REQ-017 When the counter equals STARVE_MAX and r1_req_i=1, requester 1 SHALL be granted that cycle regardless of r0_req_i, and r0_gnt_o SHALL be 0.
REQ-018 In a grant cycle, rom_cen_o SHALL be 1 and rom_addr_o SHALL equal the granted requester's address; otherwise rom_cen_o SHALL be 0 and rom_addr_o SHALL be 0.
REQ-019 The block SHALL register a 2-bit in-flight tag {valid, owner} at each grant and shift it one stage per cycle, forming a two-stage pipeline.
REQ-020 At edge G+2, where G is the grant cycle, the block SHALL:
- capture rom_data_i into the owner's data register;
- pulse the owner's valid_o high for exactly one cycle.
REQ-021 Read latency SHALL be exactly 2 cycles from grant to valid_o.
REQ-022 Back-to-back grants SHALL be accepted every cycle, giving a throughput of one read per cycle.
REQ-023 Responses SHALL return in grant order.
REQ-024 r0_data_o and r1_data_o SHALL hold their last captured value until overwritten by their own owner.
REQ-025 Deasserting en_i SHALL NOT cancel in-flight reads; the pipeline SHALL drain and deliver them normally.
REQ-026 A request withdrawn before grant SHALL produce no grant and no response.
REQ-027 A requester SHALL be able to request again in the cycle after its grant.

Reset
REQ-028 While rst_i=1, the block SHALL clear the in-flight tags and the starvation counter.
REQ-029 While rst_i=1, the block SHALL force r0_gnt_o, r1_gnt_o and rom_cen_o to 0.
REQ-030 Reset values SHALL be: r0_valid_o=0, r1_valid_o=0, r0_data_o=0, r1_data_o=0 and rom_addr_o=0.
REQ-031 Reads in flight when rst_i asserts SHALL be discarded; no valid_o pulse SHALL occur for them after reset.
REQ-032 The first grant after reset SHALL be possible in the first cycle with rst_i=0.

Verification
REQ-033 Single read: r0_req_i=1 with r0_addr_i=0x0123 for one cycle, ROM model returning 0xA -> r0_gnt_o=1 and rom_addr_o=0x0123 that cycle; r0_valid_o=1 and r0_data_o=0xA two cycles later; r1_valid_o stays 0.
REQ-034 Contention: both requesters held high continuously with STARVE_MAX=8 -> r0 granted 8 consecutive cycles, r1 granted on the 9th, pattern repeats; every grant yields the matching valid pulse 2 cycles later.
REQ-035 Streaming: r0 requests addresses 0..15 on consecutive cycles -> 16 grants with no bubbles; r0_data_o sequence matches rom[0..15] on 16 consecutive valid cycles.
REQ-036 Enable gating: en_i=0 while both requests are high for 5 cycles -> no grants, starvation counter unchanged; on en_i=1, arbitration resumes per REQ-015..017.
REQ-037 Reset mid-operation: assert rst_i for one cycle immediately after two back-to-back grants -> no valid pulses for those reads; data outputs read 0; the next request after reset completes with 2-cycle latency.
